// File: rtl/n64_aux_mailbox_pkg.sv
// Shared types and constants for the N64 AUX mailbox slice.
//   e_aux_tx_state : MCU->N64 notify/await-reply FSM states
//   AUX_WORD_W     : AUX word width
//   DROP_CNT_W     : width of the optional dropped-word counter
//   sat_inc        : saturating increment for the drop counter
package sc64_aux_pkg;

    localparam int AUX_WORD_W = 32;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_NOTIFY = 2'd1,
        TX_WAIT   = 2'd2
    } e_aux_tx_state;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/n64_aux_mailbox_if.sv
// MCU-side handshake bundle of the AUX mailbox.
//   rx_*        : N64->MCU FIFO read side (valid/ready/data/level)
//   tx_*        : MCU->N64 message offer plus done/timeout strobes
//   overflow    : sticky dropped-word flag, overflow_clr clears it
// Modports: master = MCU bridge logic, slave = the mailbox.
interface n64_aux_mailbox_if #(parameter int DEPTH = 8);
    import sc64_aux_pkg::*;

    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic                  rx_valid;
    logic                  rx_ready;
    logic [AUX_WORD_W-1:0] rx_data;
    logic [LEVEL_W-1:0]    rx_level;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [AUX_WORD_W-1:0] tx_data;
    logic                  tx_done;
    logic                  tx_timeout;
    logic                  overflow;
    logic                  overflow_clr;

    modport master (
        input  rx_valid, rx_data, rx_level, tx_ready, tx_done, tx_timeout, overflow,
        output rx_ready, tx_valid, tx_data, overflow_clr
    );

    modport slave (
        output rx_valid, rx_data, rx_level, tx_ready, tx_done, tx_timeout, overflow,
        input  rx_ready, tx_valid, tx_data, overflow_clr
    );

endinterface

// File: rtl/n64_aux_fifo.sv
// Generic synchronous FIFO with show-ahead head output.
//   clk, reset_n : clock, async active-low reset (clears storage too)
//   flush        : sync empty, highest priority after reset
//   push/din     : write; accepted when not full, or when full and popping
//   pop          : read; ignored while empty
//   full, empty, level : occupancy status
//   head         : mem[rd_ptr], combinational
module n64_aux_fifo
    import sc64_aux_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = AUX_WORD_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot being written: wr_ptr == rd_ptr.
    assign do_push = push && (!full || do_pop);
    assign level   = count;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/n64_aux_mailbox.sv
// AUX mailbox between the N64 config register block and MCU bridge logic.
//   clk, reset_n          : clock, async active-low reset
//   n64_reset, n64_nmi    : console reset/NMI levels, synchronously flush everything
//   cfg_unlock            : config interface unlocked (gates MCU->N64 sends)
//   aux_pending/aux_rdata : N64 wrote an AUX word (pushed into the RX FIFO)
//   aux_wdata/aux_irq     : MCU->N64 word and its 1-cycle post strobe
//   mcu (slave modport)   : rx/tx handshakes, done/timeout strobes, overflow
//   drop_count            : only when AUX_MAILBOX_STATS_EN is defined;
//                           saturating count of dropped N64 words
module n64_aux_mailbox
    import sc64_aux_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  n64_reset,
    input  logic                  n64_nmi,
    input  logic                  cfg_unlock,
    input  logic                  aux_pending,
    input  logic [AUX_WORD_W-1:0] aux_rdata,
    output logic [AUX_WORD_W-1:0] aux_wdata,
    output logic                  aux_irq,
    n64_aux_mailbox_if.slave      mcu
`ifdef AUX_MAILBOX_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic                 flush;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;
    logic                 tx_ready;
    logic                 tx_accept;
    e_aux_tx_state        state;
    logic [CNT_W-1:0]     cnt;
    logic                 tx_done_q;
    logic                 tx_timeout_q;
    logic                 overflow_q;

    assign flush = n64_reset || n64_nmi;

    n64_aux_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AUX_WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (aux_pending),
        .pop     (mcu.rx_ready),
        .din     (aux_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (mcu.rx_level),
        .head    (mcu.rx_data)
    );

    assign mcu.rx_valid = !fifo_empty;

    // Full implies non-empty, so rx_ready alone means the pop is effective.
    assign drop = aux_pending && fifo_full && !mcu.rx_ready && !flush;

    assign tx_ready        = (state == TX_IDLE) && cfg_unlock && !flush;
    assign tx_accept       = tx_ready && mcu.tx_valid;
    assign mcu.tx_ready    = tx_ready;
    assign mcu.tx_done     = tx_done_q;
    assign mcu.tx_timeout  = tx_timeout_q;
    assign mcu.overflow    = overflow_q;

    // aux_irq is raised on the accepting edge so it is high during NOTIFY only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= TX_IDLE;
            cnt          <= '0;
            aux_wdata    <= '0;
            aux_irq      <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else if (flush) begin
            state        <= TX_IDLE;
            cnt          <= '0;
            aux_wdata    <= '0;
            aux_irq      <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else begin
            aux_irq      <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_timeout_q <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (tx_accept) begin
                        aux_wdata <= mcu.tx_data;
                        cnt       <= '0;
                        aux_irq   <= 1'b1;
                        state     <= TX_NOTIFY;
                    end
                end
                TX_NOTIFY: begin
                    state <= TX_WAIT;
                end
                TX_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (aux_pending) begin
                        tx_done_q <= 1'b1;
                        state     <= TX_IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1) || !cfg_unlock) begin
                        tx_timeout_q <= 1'b1;
                        state        <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (mcu.overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef AUX_MAILBOX_STATS_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else if (flush) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end else if (mcu.overflow_clr) begin
            drop_cnt_q <= '0;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_n64_aux_mailbox.sv
// Self-checking bench for n64_aux_mailbox (DEPTH=8, TIMEOUT_CYCLES=16).
// A transaction-level reference model (queue for the RX FIFO, timestamps for
// the MCU->N64 message) predicts every output after each clock edge.
module tb_n64_aux_mailbox;
    import sc64_aux_pkg::*;

    localparam int DEPTH = 8;
    localparam int T     = 16;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        n64_reset   = 1'b0;
    logic        n64_nmi     = 1'b0;
    logic        cfg_unlock  = 1'b0;
    logic        aux_pending = 1'b0;
    logic [31:0] aux_rdata   = '0;
    logic [31:0] aux_wdata;
    logic        aux_irq;
`ifdef AUX_MAILBOX_STATS_EN
    logic [15:0] drop_count;
`endif

    n64_aux_mailbox_if #(.DEPTH(DEPTH)) mcu ();

    n64_aux_mailbox #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .n64_reset   (n64_reset),
        .n64_nmi     (n64_nmi),
        .cfg_unlock  (cfg_unlock),
        .aux_pending (aux_pending),
        .aux_rdata   (aux_rdata),
        .aux_wdata   (aux_wdata),
        .aux_irq     (aux_irq),
        .mcu         (mcu)
`ifdef AUX_MAILBOX_STATS_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] q[$];
    bit          m_ovf;
    int          m_dc;
    bit          busy;
    int          acc;
    logic [31:0] m_wdata;
    int          cyc;
    bit          e_irq, e_done, e_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit flush_now();
        return n64_reset || n64_nmi;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_dc    = 0;
        busy    = 1'b0;
        m_wdata = '0;
        e_irq   = 1'b0;
        e_done  = 1'b0;
        e_to    = 1'b0;
    endtask

    task automatic check_all();
        chk("rx_valid", 32'(mcu.rx_valid), 32'(q.size() != 0));
        chk("rx_level", 32'(mcu.rx_level), 32'(q.size()));
        if (q.size() != 0) chk("rx_data", mcu.rx_data, q[0]);
        chk("overflow", 32'(mcu.overflow), 32'(m_ovf));
        chk("aux_irq", 32'(aux_irq), 32'(e_irq));
        chk("tx_done", 32'(mcu.tx_done), 32'(e_done));
        chk("tx_timeout", 32'(mcu.tx_timeout), 32'(e_to));
        chk("aux_wdata", aux_wdata, m_wdata);
        chk("tx_ready", 32'(mcu.tx_ready), 32'(!busy && cfg_unlock && !flush_now()));
`ifdef AUX_MAILBOX_STATS_EN
        chk("drop_count", 32'(drop_count), 32'(m_dc));
`endif
    endtask

    // Predict the effect of the coming edge from current inputs, clock, check.
    task automatic tick();
        int e;
        bit pop;
        bit drop;
        e      = cyc + 1;
        e_irq  = 1'b0;
        e_done = 1'b0;
        e_to   = 1'b0;
        if (flush_now()) begin
            q.delete();
            m_ovf   = 1'b0;
            m_dc    = 0;
            busy    = 1'b0;
            m_wdata = '0;
        end else begin
            pop  = mcu.rx_ready && (q.size() != 0);
            drop = aux_pending && (q.size() == DEPTH) && !pop;
            if (drop) begin
                m_ovf = 1'b1;
                if (m_dc < 65535) m_dc++;
            end else if (mcu.overflow_clr) begin
                m_ovf = 1'b0;
                m_dc  = 0;
            end
            if (pop) void'(q.pop_front());
            if (aux_pending && !drop) q.push_back(aux_rdata);
            // A sent message is notified on the edge after acceptance, then
            // waits T edges for a reply; unlock loss ends the wait early.
            if (busy && e >= acc + 2) begin
                if (aux_pending) begin
                    e_done = 1'b1;
                    busy   = 1'b0;
                end else if (e == acc + 1 + T || !cfg_unlock) begin
                    e_to = 1'b1;
                    busy = 1'b0;
                end
            end else if (!busy && mcu.tx_valid && cfg_unlock) begin
                busy    = 1'b1;
                acc     = e;
                m_wdata = mcu.tx_data;
                e_irq   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc = e;
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1);
    end

    initial begin
        int irq_cyc;
        int seen;
        model_reset();
        cyc              = 0;
        mcu.rx_ready     = 1'b0;
        mcu.tx_valid     = 1'b0;
        mcu.tx_data      = '0;
        mcu.overflow_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_valid", 32'(mcu.rx_valid), 32'd0);
        chk("rst_rx_level", 32'(mcu.rx_level), 32'd0);
        chk("rst_rx_data", mcu.rx_data, 32'd0);
        chk("rst_aux_irq", 32'(aux_irq), 32'd0);
        chk("rst_aux_wdata", aux_wdata, 32'd0);
        chk("rst_overflow", 32'(mcu.overflow), 32'd0);
        chk("rst_tx_done", 32'(mcu.tx_done), 32'd0);
        chk("rst_tx_timeout", 32'(mcu.tx_timeout), 32'd0);
        chk("rst_tx_ready", 32'(mcu.tx_ready), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: three words in, popped in order
        for (int i = 0; i < 3; i++) begin
            aux_pending = 1'b1;
            aux_rdata   = 32'(32'h11111111 * (i + 1));
            tick();
        end
        aux_pending = 1'b0;
        chk("t1_level3", 32'(mcu.rx_level), 32'd3);
        mcu.rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_head", mcu.rx_data, 32'(32'h11111111 * (i + 1)));
            tick();
        end
        mcu.rx_ready = 1'b0;
        chk("t1_level0", 32'(mcu.rx_level), 32'd0);
        chk("t1_overflow", 32'(mcu.overflow), 32'd0);

        // 2: ten pushes into eight slots
        for (int i = 0; i < 10; i++) begin
            aux_pending = 1'b1;
            aux_rdata   = 32'hB0000000 + 32'(i);
            tick();
        end
        aux_pending = 1'b0;
        chk("t2_level8", 32'(mcu.rx_level), 32'd8);
        chk("t2_overflow", 32'(mcu.overflow), 32'd1);
`ifdef AUX_MAILBOX_STATS_EN
        chk("t2_drop_count", 32'(drop_count), 32'd2);
`endif
        mcu.overflow_clr = 1'b1;
        tick();
        mcu.overflow_clr = 1'b0;
        chk("t2_ovf_clr", 32'(mcu.overflow), 32'd0);

        // 3: push+pop on a full FIFO
        aux_pending  = 1'b1;
        aux_rdata    = 32'hA5A50003;
        mcu.rx_ready = 1'b1;
        tick();
        aux_pending = 1'b0;
        chk("t3_level8", 32'(mcu.rx_level), 32'd8);
        chk("t3_head", mcu.rx_data, 32'hB0000001);
        repeat (7) tick();
        chk("t3_last", mcu.rx_data, 32'hA5A50003);
        chk("t3_level1", 32'(mcu.rx_level), 32'd1);
        tick();
        mcu.rx_ready = 1'b0;

        // 4: send, then reply five cycles later
        cfg_unlock   = 1'b1;
        mcu.tx_valid = 1'b1;
        mcu.tx_data  = 32'hCAFEBABE;
        tick();
        mcu.tx_valid = 1'b0;
        chk("t4_irq", 32'(aux_irq), 32'd1);
        chk("t4_wdata", aux_wdata, 32'hCAFEBABE);
        chk("t4_busy", 32'(mcu.tx_ready), 32'd0);
        repeat (4) tick();
        aux_pending = 1'b1;
        aux_rdata   = 32'h0BADF00D;
        tick();
        aux_pending = 1'b0;
        chk("t4_done", 32'(mcu.tx_done), 32'd1);
        chk("t4_ready", 32'(mcu.tx_ready), 32'd1);
        chk("t4_reply", mcu.rx_data, 32'h0BADF00D);
        tick();

        // 5: no reply -> timeout after T cycles of waiting
        mcu.rx_ready = 1'b1;
        tick();
        mcu.rx_ready = 1'b0;
        mcu.tx_valid = 1'b1;
        mcu.tx_data  = $urandom;
        tick();
        mcu.tx_valid = 1'b0;
        irq_cyc = cyc;
        seen    = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mcu.tx_timeout && seen < 0) seen = cyc;
        end
        chk("t5_timeout_delay", 32'(seen - irq_cyc), 32'(T + 1));
        cfg_unlock = 1'b0;
        tick();
        chk("t5_locked_ready", 32'(mcu.tx_ready), 32'd0);
        // unlock lost while waiting
        cfg_unlock   = 1'b1;
        mcu.tx_valid = 1'b1;
        tick();
        mcu.tx_valid = 1'b0;
        repeat (3) tick();
        cfg_unlock = 1'b0;
        tick();
        chk("t5_unlock_timeout", 32'(mcu.tx_timeout), 32'd1);
        cfg_unlock = 1'b1;
        tick();

        // 6: NMI flush with four words queued and a message in flight
        for (int i = 0; i < 4; i++) begin
            aux_pending = 1'b1;
            aux_rdata   = $urandom;
            tick();
        end
        aux_pending  = 1'b0;
        mcu.tx_valid = 1'b1;
        mcu.tx_data  = 32'h13572468;
        tick();
        mcu.tx_valid = 1'b0;
        repeat (2) tick();
        chk("t6_level4", 32'(mcu.rx_level), 32'd4);
        n64_nmi = 1'b1;
        tick();
        chk("t6_flush_level", 32'(mcu.rx_level), 32'd0);
        chk("t6_flush_wdata", aux_wdata, 32'd0);
        n64_nmi = 1'b0;
        tick();
        chk("t6_idle_ready", 32'(mcu.tx_ready), 32'd1);

        // 6b: asynchronous reset in the middle of a wait
        aux_pending = 1'b1;
        aux_rdata   = 32'h5A5A5A5A;
        tick();
        aux_pending  = 1'b0;
        mcu.tx_valid = 1'b1;
        mcu.tx_data  = 32'hDEAD0001;
        tick();
        mcu.tx_valid = 1'b0;
        repeat (3) tick();
        #3;
        reset_n    = 1'b0;
        cfg_unlock = 1'b0;
        #1;
        chk("t6r_aux_wdata", aux_wdata, 32'd0);
        chk("t6r_aux_irq", 32'(aux_irq), 32'd0);
        chk("t6r_rx_valid", 32'(mcu.rx_valid), 32'd0);
        chk("t6r_rx_level", 32'(mcu.rx_level), 32'd0);
        chk("t6r_rx_data", mcu.rx_data, 32'd0);
        chk("t6r_tx_ready", 32'(mcu.tx_ready), 32'd0);
        chk("t6r_tx_timeout", 32'(mcu.tx_timeout), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        cfg_unlock = 1'b1;
        tick();

        // Randomized traffic: a light phase then a congested one
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 400; i++) begin
                aux_pending      = (ph == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
                aux_rdata        = $urandom;
                mcu.rx_ready     = (ph == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
                mcu.tx_valid     = ($urandom_range(0, 3) == 0);
                mcu.tx_data      = $urandom;
                cfg_unlock       = ($urandom_range(0, 15) != 0);
                mcu.overflow_clr = ($urandom_range(0, 15) == 0);
                n64_nmi          = ($urandom_range(0, 63) == 0);
                n64_reset        = ($urandom_range(0, 96) == 0);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
